// File: rtl/i2c_cmd_seq_if.sv
// Request/response handshake and reg-bus master signals of the I2C command sequencer.
// The sequencer uses the master modport; the request agent / reg-bus target side uses slave.
interface i2c_cmd_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        reg_mst_cs;
  logic        reg_mst_wr;
  logic [10:0] reg_mst_addr;
  logic [31:0] reg_mst_wdata;
  logic [3:0]  reg_mst_be;
  logic [31:0] reg_mst_rdata;
  logic        reg_mst_ack;

  modport master (
    input  req_valid, req_wr, req_dev, req_reg, req_wdata, reg_mst_rdata, reg_mst_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output reg_mst_cs, reg_mst_wr, reg_mst_addr, reg_mst_wdata, reg_mst_be
  );

  modport slave (
    output req_valid, req_wr, req_dev, req_reg, req_wdata, reg_mst_rdata, reg_mst_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  reg_mst_cs, reg_mst_wr, reg_mst_addr, reg_mst_wdata, reg_mst_be
  );
endinterface

// File: rtl/i2c_cmd_seq.sv
// Reg-bus master that turns single-byte I2C register read/write requests into
// the prescale/control/transmit/command/status access sequence of the byte-wide I2C core.
module i2c_cmd_seq #(
  parameter logic [2:0]  BLK_SEL  = 3'b000,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic          app_clk,
  input  logic          reset_n,
  input  logic [15:0]   cfg_prescale,
  i2c_cmd_seq_if.master bus
);

  typedef enum logic [2:0] {INIT, IDLE, ACC, POLL, CHECK, ABORT, RESP} state_t;
  typedef struct packed { logic wr; logic [2:0] idx; logic [7:0] data; } acc_t;

  localparam logic [2:0] IDX_TXR = 3'd3;
  localparam logic [2:0] IDX_CR  = 3'd4;

  function automatic acc_t mk_acc(input logic wr, input logic [2:0] idx, input logic [7:0] data);
    acc_t a;
    a.wr = wr; a.idx = idx; a.data = data;
    return a;
  endfunction

  function automatic acc_t init_acc(input logic [2:0] step, input logic [15:0] pre);
    case (step)
      3'd0:    return mk_acc(1'b1, 3'd0, pre[7:0]);
      3'd1:    return mk_acc(1'b1, 3'd1, pre[15:8]);
      default: return mk_acc(1'b1, 3'd2, 8'h80);
    endcase
  endfunction

  // Even steps load TXR, odd steps (and 6) issue a CR command; step 7 reads RXR.
  function automatic acc_t txn_acc(input logic [2:0] step, input logic wr, input logic [6:0] dev,
                                   input logic [7:0] rg, input logic [7:0] wd);
    case (step)
      3'd0:    return mk_acc(1'b1, IDX_TXR, {dev, 1'b0});
      3'd1:    return mk_acc(1'b1, IDX_CR, 8'h90);
      3'd2:    return mk_acc(1'b1, IDX_TXR, rg);
      3'd3:    return mk_acc(1'b1, IDX_CR, 8'h10);
      3'd4:    return mk_acc(1'b1, IDX_TXR, wr ? wd : {dev, 1'b1});
      3'd5:    return mk_acc(1'b1, IDX_CR, wr ? 8'h50 : 8'h90);
      3'd6:    return mk_acc(1'b1, IDX_CR, 8'h68);
      default: return mk_acc(1'b0, IDX_TXR, 8'h00);
    endcase
  endfunction

  function automatic logic [10:0] mk_addr(input logic [2:0] idx);
    return {2'b00, BLK_SEL, 1'b0, idx, 2'b00};
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] poll_q, poll_d;
  logic [2:0]  sr_q, sr_d;
  logic        init_done_q, init_done_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cap_wr;
  logic [6:0]  cap_dev;
  logic [7:0]  cap_reg, cap_wdata;
  logic        ready, take, launch, last_rd, unused_rdata_hi;
  acc_t        la;

  assign ready   = (state_q == IDLE) && init_done_q;
  assign take    = bus.req_valid && ready;
  assign last_rd = !cap_wr && (step_q == 3'd6);

  assign bus.req_ready     = ready;
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;
  assign bus.reg_mst_cs    = cs_q;
  assign bus.reg_mst_wr    = wr_q;
  assign bus.reg_mst_addr  = addr_q;
  assign bus.reg_mst_wdata = {24'h000000, wbyte_q};
  assign bus.reg_mst_be    = 4'b0001;
  assign unused_rdata_hi   = ^bus.reg_mst_rdata[31:8];

  always_ff @(posedge app_clk) begin
    if (take) begin
      cap_wr    <= bus.req_wr;
      cap_dev   <= bus.req_dev;
      cap_reg   <= bus.req_reg;
      cap_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      step_q      <= '0;
      poll_q      <= '0;
      sr_q        <= '0;
      init_done_q <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wbyte_q     <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      poll_q      <= poll_d;
      sr_q        <= sr_d;
      init_done_q <= init_done_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wbyte_q     <= wbyte_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Each access-issuing state launches while cs is low and finishes on ack,
  // so cs is always low for at least one cycle between accesses.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    poll_d      = poll_q;
    sr_d        = sr_q;
    init_done_d = init_done_q;
    cs_d        = cs_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wbyte_d     = wbyte_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    launch      = 1'b0;
    la          = mk_acc(1'b0, 3'd0, 8'h00);
    case (state_q)
      INIT: begin
        if (!cs_q) begin
          la = init_acc(step_q, cfg_prescale);
          launch = 1'b1;
        end else if (bus.reg_mst_ack) begin
          cs_d = 1'b0;
          if (step_q == 3'd2) begin
            step_d      = '0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      IDLE: begin
        if (take) begin
          step_d  = '0;
          err_d   = 2'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (!cs_q) begin
          la = txn_acc(step_q, cap_wr, cap_dev, cap_reg, cap_wdata);
          launch = 1'b1;
        end else if (bus.reg_mst_ack) begin
          cs_d = 1'b0;
          if (!wr_q) begin
            rdata_d = bus.reg_mst_rdata[7:0];
            state_d = RESP;
          end else if (addr_q[4:2] == IDX_TXR) begin
            step_d = step_q + 3'd1;
          end else begin
            poll_d  = '0;
            state_d = POLL;
          end
        end
      end
      POLL: begin
        if (!cs_q) begin
          la = mk_acc(1'b0, IDX_CR, 8'h00);
          launch = 1'b1;
        end else if (bus.reg_mst_ack) begin
          cs_d    = 1'b0;
          sr_d    = {bus.reg_mst_rdata[7], bus.reg_mst_rdata[5], bus.reg_mst_rdata[1]};
          poll_d  = poll_q + 16'd1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // sr_q = {RxACK, AL, TIP}
        if (sr_q[0]) begin
          if (poll_q >= POLL_MAX) begin
            err_d   = 2'd3;
            state_d = ABORT;
          end else begin
            state_d = POLL;
          end
        end else if (sr_q[1]) begin
          err_d   = 2'd2;
          state_d = RESP;
        end else if (sr_q[2] && !last_rd) begin
          err_d   = 2'd1;
          state_d = ABORT;
        end else if (cap_wr && step_q == 3'd5) begin
          state_d = RESP;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = ACC;
        end
      end
      ABORT: begin
        if (!cs_q) begin
          la = mk_acc(1'b1, IDX_CR, 8'h40);
          launch = 1'b1;
        end else if (bus.reg_mst_ack) begin
          cs_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase
    if (launch) begin
      cs_d    = 1'b1;
      wr_d    = la.wr;
      addr_d  = mk_addr(la.idx);
      wbyte_d = la.data;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Bench for i2c_cmd_seq: reg-bus responder emulating the I2C core plus a
// transaction-level model of the expected access list and response.
module tb_i2c_cmd_seq;
  localparam logic [2:0] BLK  = 3'b101;
  localparam int         PMAX = 8;

  logic        app_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cfg_prescale;
  always #5 app_clk = ~app_clk;

  i2c_cmd_seq_if bus_if();

  i2c_cmd_seq #(.BLK_SEL(BLK), .POLL_MAX(16'(PMAX))) dut (
    .app_clk      (app_clk),
    .reset_n      (reset_n),
    .cfg_prescale (cfg_prescale),
    .bus          (bus_if)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // core emulation knobs, written only by the stimulus process
  int         tip_tab[4];
  int         nack_byte, al_byte;
  bit         stuck;
  logic [7:0] rx_byte;

  // responder state
  logic [11:0] log_q[$];
  int          bad_acc = 0, rsp_cnt = 0;
  int          wt, byte_cnt, cur_byte, tip_left;
  logic        cs_prev, after_ack;
  logic        h_wr;
  logic [10:0] h_addr;
  logic [31:0] h_wdata;

  always @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_if.reg_mst_ack   <= 1'b0;
      bus_if.reg_mst_rdata <= '0;
      wt <= 0; byte_cnt <= 0; cur_byte <= 0; tip_left <= 0;
      cs_prev <= 1'b0; after_ack <= 1'b0;
    end else begin
      cs_prev   <= bus_if.reg_mst_cs;
      after_ack <= bus_if.reg_mst_ack;
      if (bus_if.rsp_valid) begin
        rsp_cnt  <= rsp_cnt + 1;
        byte_cnt <= 0;
      end
      if (after_ack && bus_if.reg_mst_cs) bad_acc <= bad_acc + 1;
      if (bus_if.reg_mst_ack) begin
        bus_if.reg_mst_ack <= 1'b0;
      end else if (bus_if.reg_mst_cs) begin
        if (!cs_prev) begin
          h_wr <= bus_if.reg_mst_wr; h_addr <= bus_if.reg_mst_addr; h_wdata <= bus_if.reg_mst_wdata;
          if (bus_if.reg_mst_be != 4'b0001 || bus_if.reg_mst_wdata[31:8] != 24'h0 ||
              bus_if.reg_mst_addr[10:9] != 2'b00 || bus_if.reg_mst_addr[8:6] != BLK ||
              bus_if.reg_mst_addr[5] != 1'b0 || bus_if.reg_mst_addr[1:0] != 2'b00)
            bad_acc <= bad_acc + 1;
        end else if (h_wr != bus_if.reg_mst_wr || h_addr != bus_if.reg_mst_addr ||
                     h_wdata != bus_if.reg_mst_wdata) begin
          bad_acc <= bad_acc + 1;
        end
        if (wt == 0) begin
          bus_if.reg_mst_ack <= 1'b1;
          wt <= $urandom_range(0, 2);
          log_q.push_back({bus_if.reg_mst_wr, bus_if.reg_mst_addr[4:2],
                           bus_if.reg_mst_wr ? bus_if.reg_mst_wdata[7:0] : 8'h00});
          if (bus_if.reg_mst_wr && bus_if.reg_mst_addr[4:2] == 3'd4 && bus_if.reg_mst_wdata[7:0] != 8'h40) begin
            cur_byte <= byte_cnt;
            tip_left <= (byte_cnt < 4) ? tip_tab[byte_cnt] : 0;
            byte_cnt <= byte_cnt + 1;
            bus_if.reg_mst_rdata <= '0;
          end else if (!bus_if.reg_mst_wr && bus_if.reg_mst_addr[4:2] == 3'd4) begin
            if (stuck || tip_left > 0) begin
              bus_if.reg_mst_rdata <= {24'($urandom), 8'h02};
              if (tip_left > 0) tip_left <= tip_left - 1;
            end else begin
              bus_if.reg_mst_rdata <= {24'($urandom), cur_byte == nack_byte, 1'b0, cur_byte == al_byte, 5'b0};
            end
          end else if (!bus_if.reg_mst_wr && bus_if.reg_mst_addr[4:2] == 3'd3) begin
            bus_if.reg_mst_rdata <= {24'($urandom), rx_byte};
          end else begin
            bus_if.reg_mst_rdata <= '0;
          end
        end else begin
          wt <= wt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // transaction-level expectation: access list, error code, read data
  logic [11:0] exp_q[$];
  logic [1:0]  exp_err;
  logic [7:0]  exp_rdata = 8'h00;

  task automatic model(input bit w, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int nb, np;
    bit done;
    exp_q.delete();
    exp_err = 2'd0;
    nb   = w ? 3 : 4;
    txr  = '{{dev, 1'b0}, rg, w ? wd : {dev, 1'b1}, 8'h00};
    cr   = '{8'h90, 8'h10, w ? 8'h50 : 8'h90, 8'h68};
    done = 0;
    for (int b = 0; b < nb && !done; b++) begin
      if (b < 3) exp_q.push_back({1'b1, 3'd3, txr[b]});
      exp_q.push_back({1'b1, 3'd4, cr[b]});
      np = stuck ? PMAX : tip_tab[b] + 1;
      for (int p = 0; p < np; p++) exp_q.push_back({1'b0, 3'd4, 8'h00});
      if (stuck) begin
        exp_q.push_back({1'b1, 3'd4, 8'h40}); exp_err = 2'd3; done = 1;
      end else if (b == al_byte) begin
        exp_err = 2'd2; done = 1;
      end else if (b == nack_byte && !(!w && b == 3)) begin
        exp_q.push_back({1'b1, 3'd4, 8'h40}); exp_err = 2'd1; done = 1;
      end
    end
    if (!done && !w) begin
      exp_q.push_back({1'b0, 3'd3, 8'h00});
      exp_rdata = rx_byte;
    end
  endtask

  task automatic send_req(input string tag, input bit w, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd);
    for (int k = 0; k < 200 && !bus_if.req_ready; k++) @(negedge app_clk);
    check({tag, "_ready"}, 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1; bus_if.req_wr = w;
    bus_if.req_dev = dev; bus_if.req_reg = rg; bus_if.req_wdata = wd;
    @(posedge app_clk); #1;
    bus_if.req_valid = 1'b0;
    check({tag, "_ready_drop"}, 32'(bus_if.req_ready), 32'd0);
  endtask

  task automatic run_txn(input string tag, input bit w, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd);
    int base, n, seen;
    logic [1:0] e;
    logic [7:0] d;
    model(w, dev, rg, wd);
    base = log_q.size();
    send_req(tag, w, dev, rg, wd);
    seen = 0; e = '0; d = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge app_clk);
      if (bus_if.rsp_valid) begin seen = 1; e = bus_if.rsp_err; d = bus_if.rsp_rdata; break; end
    end
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    @(negedge app_clk);
    check({tag, "_rsp_one_cycle"}, 32'(bus_if.rsp_valid), 32'd0);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_rdata"}, 32'(d), 32'(exp_rdata));
    n = log_q.size() - base;
    check({tag, "_n_acc"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_acc%0d", tag, i), 32'(log_q[base + i]), 32'(exp_q[i]));
    check({tag, "_bus_rules"}, 32'(bad_acc), 32'd0);
  endtask

  task automatic check_init(input string tag, input logic [15:0] pre, input int base);
    int n;
    for (int k = 0; k < 200 && !bus_if.req_ready; k++) @(negedge app_clk);
    check({tag, "_ready"}, 32'(bus_if.req_ready), 32'd1);
    n = log_q.size() - base;
    check({tag, "_n_acc"}, 32'(n), 32'd3);
    if (n >= 3) begin
      check({tag, "_prer_lo"}, 32'(log_q[base]),     32'({1'b1, 3'd0, pre[7:0]}));
      check({tag, "_prer_hi"}, 32'(log_q[base + 1]), 32'({1'b1, 3'd1, pre[15:8]}));
      check({tag, "_ctr"},     32'(log_q[base + 2]), 32'({1'b1, 3'd2, 8'h80}));
    end
  endtask

  initial begin
    int base, snap, kind, found;
    bit w;
    bus_if.req_valid = 1'b0; bus_if.req_wr = 1'b0; bus_if.req_dev = '0;
    bus_if.req_reg = '0; bus_if.req_wdata = '0;
    cfg_prescale = 16'h0063;
    tip_tab = '{0, 0, 0, 0}; nack_byte = 7; al_byte = 7; stuck = 0; rx_byte = 8'h00;

    repeat (3) @(negedge app_clk);
    check("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    check("rst_cs",        32'(bus_if.reg_mst_cs), 32'd0);
    check("rst_wr",        32'(bus_if.reg_mst_wr), 32'd0);
    check("rst_addr",      32'(bus_if.reg_mst_addr), 32'd0);
    check("rst_wdata",     bus_if.reg_mst_wdata, 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(bus_if.rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    base = log_q.size();
    reset_n = 1'b1;
    check_init("init", 16'h0063, base);

    tip_tab = '{1, 0, 2, 1};
    run_txn("wr_a5", 1'b1, 7'h50, 8'h10, 8'hA5);
    rx_byte = 8'h3C;
    run_txn("rd_3c", 1'b0, 7'h50, 8'h22, 8'h00);
    nack_byte = 0;
    run_txn("no_slave", 1'b1, 7'h11, 8'h05, 8'h77);
    nack_byte = 7; stuck = 1;
    run_txn("tip_stuck", 1'b1, 7'h2A, 8'h01, 8'h02);
    stuck = 0; al_byte = 1; rx_byte = 8'hE7;
    run_txn("arb_lost", 1'b0, 7'h33, 8'h44, 8'h00);
    al_byte = 7; nack_byte = 3; rx_byte = 8'h5A;
    run_txn("rd_last_nack", 1'b0, 7'h7F, 8'hFF, 8'h00);
    nack_byte = 7;

    for (int t = 0; t < 12; t++) begin
      w = 1'($urandom_range(0, 1));
      rx_byte = 8'($urandom);
      for (int b = 0; b < 4; b++) tip_tab[b] = $urandom_range(0, 3);
      nack_byte = 7; al_byte = 7; stuck = 0;
      kind = $urandom_range(0, 9);
      if (kind == 6 || kind == 7) nack_byte = $urandom_range(0, w ? 2 : 3);
      else if (kind == 8) al_byte = $urandom_range(0, w ? 2 : 3);
      else if (kind == 9) stuck = 1;
      run_txn($sformatf("rnd%0d", t), w, 7'($urandom), 8'($urandom), 8'($urandom));
    end

    // reset while a status poll is on the bus
    nack_byte = 7; al_byte = 7; stuck = 0; tip_tab = '{3, 3, 3, 3};
    send_req("rst_mid", 1'b1, 7'h50, 8'h10, 8'hC3);
    found = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge app_clk);
      if (bus_if.reg_mst_cs && !bus_if.reg_mst_wr && bus_if.reg_mst_addr[4:2] == 3'd4) begin
        found = 1; break;
      end
    end
    check("rst_mid_poll_seen", 32'(found), 32'd1);
    snap = rsp_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_cs_async", 32'(bus_if.reg_mst_cs), 32'd0);
    check("rst_mid_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    repeat (2) @(negedge app_clk);
    cfg_prescale = 16'h1234;
    exp_rdata = 8'h00;
    base = log_q.size();
    reset_n = 1'b1;
    check_init("reinit", 16'h1234, base);
    check("rst_mid_no_rsp", 32'(rsp_cnt), 32'(snap));

    tip_tab = '{0, 1, 0, 2}; rx_byte = 8'h96;
    run_txn("post_rst", 1'b0, 7'h48, 8'h0C, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_seq.md
Name: i2c_cmd_seq

Overview:
Autonomous reg-bus master sitting directly upstream of the I2C wrapper; drives its reg_slv_* slave port to program the embedded byte-wide I2C master core. Converts single-byte device register read/write requests into the prescale/control/transmit/command/status register access sequences, and reports read data and completion status. Lets hardware agents (boot loader, sensor poller) use I2C without CPU involvement.

Parameters:
BLK_SEL, 3'b000, value placed on reg_mst_addr[8:6] to select the I2C master block
POLL_MAX, 16'hFFFF, maximum status polls per byte before timeout abort

Ports:
app_clk  input  1  block clock (same clock as the I2C wrapper app_clk)
reset_n  input  1  asynchronous active-low reset
cfg_prescale  input  16  SCL prescale value written during init
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_wr  input  1  1 = register write, 0 = register read
req_dev  input  7  7-bit I2C device address
req_reg  input  8  device register address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  8  read data, valid with rsp_valid
rsp_err  output  2  0 ok, 1 NACK, 2 arbitration lost, 3 poll timeout
reg_mst_cs  output  1  reg-bus chip select
reg_mst_wr  output  1  reg-bus write
reg_mst_addr  output  11  byte address: [8:6]=BLK_SEL, [4:2]=core register index, others 0
reg_mst_wdata  output  32  write data, [31:8]=0
reg_mst_be  output  4  always 4'b0001
reg_mst_rdata  input  32  read data, only [7:0] used
reg_mst_ack  input  1  access complete

Behaviour:
- Clock/reset: one clock app_clk; reset_n asynchronous, active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_mst_cs=0, reg_mst_wr=0, reg_mst_addr=0, reg_mst_wdata=0, FSM=INIT, init_done=0.
- Core register index: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR(wr)/RXR(rd), 4 CR(wr)/SR(rd). SR bit1 TIP, bit5 AL, bit7 RxACK.
- Bus rule: cs, wr, addr, wdata held stable from assertion until the cycle reg_mst_ack=1; cs drops the cycle after ack, stays low ≥1 cycle between accesses. No own bus timeout.
- States: INIT, IDLE, ACC (bus access in flight), POLL (read SR), CHECK, ABORT, RESP.
- INIT: writes PRERlo=cfg_prescale[7:0], PRERhi=cfg_prescale[15:8], CTR=8'h80; cfg_prescale sampled only here; -> IDLE.
- IDLE: req_ready=1; on handshake capture req_* into local regs, req_ready=0 next cycle; req_ready low in all other states.
- Write sequence (per byte: TXR write, CR write, poll): {dev,0}+CR 8'h90; reg+CR 8'h10; wdata+CR 8'h50.
- Read sequence: {dev,0}+8'h90; reg+8'h10; {dev,1}+8'h90 (repeated start); CR 8'h68 (RD|NACK|STO), poll; then read RXR -> rsp_rdata.
- POLL: read SR repeatedly until TIP=0; poll count resets per byte; count reaching POLL_MAX with TIP=1 -> ABORT err=3.
- CHECK (TIP=0): AL=1 -> RESP err=2 (no STOP, core already released bus); RxACK=1 on any transmitted byte -> ABORT err=1; else next step. RxACK ignored after the final read byte.
- ABORT: write CR=8'h40 (STO), no poll, -> RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_err; rsp_rdata updated only on successful read, else holds previous value; -> IDLE.
- Final write byte/read stop: sequence complete after its poll shows TIP=0 (err=0).
- reset_n low mid-sequence: all state cleared immediately, init repeated; any in-flight transfer abandoned (I2C core reset separately).

Test Plan:
- Reset release, cfg_prescale=16'h0063 -> writes 0x63 @idx0, 0x00 @idx1, 0x80 @idx2 in order; then req_ready=1.
- Write dev=7'h50 reg=8'h10 data=8'hA5, slave ACKs all -> TXR 8'hA0/CR 8'h90, TXR 8'h10/CR 8'h10, TXR 8'hA5/CR 8'h50; rsp_valid one cycle, rsp_err=0.
- Read dev=7'h50 reg=8'h22, slave returns 8'h3C -> TXR 8'hA0, 8'h22, 8'hA1 with CR 8'h90/10/90, CR 8'h68, RXR read; rsp_rdata=8'h3C, rsp_err=0.
- No slave at dev=7'h11 (RxACK=1 on first byte) -> CR 8'h40 written, rsp_err=1, no further TXR writes.
- SR forced TIP=1 with POLL_MAX=16'd8 -> exactly 8 SR reads, CR 8'h40, rsp_err=3.
- reset_n pulsed low during POLL -> cs low same cycle asynchronously, rsp_valid never asserted, INIT sequence reissued after release.
